// File: rtl/rob_commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rob_commit_ctrl_pkg
//   Shared constants and helpers for the reorder-buffer commit controller.
//
//   ROB_SIZE  number of tag slots (tag 0 is reserved as "no tag")
//   ROB_W     tag width, log2(ROB_SIZE)
//   DATA_W    result/value width
//   REG_W     architectural register index width
//
//   next_tag() walks the circular tag space 1..ROB_SIZE-1 and never yields
//   tag 0, which the register file uses to mean "value is architectural".
// ---------------------------------------------------------------------------
package rob_commit_ctrl_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_W    = 4;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;

  localparam logic [ROB_W-1:0] ZERO_ROB  = '0;
  localparam logic [REG_W-1:0] ZERO_REG  = '0;
  localparam logic [ROB_W-1:0] ONE_ROB   = ROB_W'(1);
  localparam logic [ROB_W-1:0] FIRST_TAG = ROB_W'(1);
  localparam logic [ROB_W-1:0] LAST_TAG  = ROB_W'(ROB_SIZE - 1);

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Circular successor that skips the reserved tag 0.
  function automatic logic [ROB_W-1:0] next_tag(input logic [ROB_W-1:0] tag);
    if (tag == LAST_TAG) begin
      return FIRST_TAG;
    end
    return tag + ONE_ROB;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_tag_forward.sv
// ---------------------------------------------------------------------------
// rob_tag_forward
//   Combinational operand lookup for one decoder query port. Returns the
//   value belonging to a ROB tag if it is already known, either from the
//   result being broadcast on the CDB this very cycle (bypass) or from a
//   captured-but-not-yet-retired ROB entry.
//
//   q_tag      in   tag read from the register file for this operand
//   cdb_valid  in   CDB broadcast present this cycle
//   cdb_tag    in   tag of the broadcast
//   cdb_value  in   value of the broadcast
//   ent_valid  in   per-slot valid bits (registered)
//   ent_ready  in   per-slot result-captured bits (registered)
//   ent_value  in   per-slot captured values (registered)
//   q_ready    out  operand value is available
//   q_value    out  operand value, 0 when not available
// ---------------------------------------------------------------------------
module rob_tag_forward
  import rob_commit_ctrl_pkg::*;
(
  input  logic                             [ROB_W-1:0]  q_tag,
  input  logic                                          cdb_valid,
  input  logic                             [ROB_W-1:0]  cdb_tag,
  input  logic                             [DATA_W-1:0] cdb_value,
  input  logic [ROB_SIZE-1:0]                           ent_valid,
  input  logic [ROB_SIZE-1:0]                           ent_ready,
  input  logic [ROB_SIZE-1:0]              [DATA_W-1:0] ent_value,
  output logic                                          q_ready,
  output logic                             [DATA_W-1:0] q_value
);

  // Tag 0 means "no rename", so it never reports a forwarded value even if
  // a stray broadcast carries tag 0. The live CDB value wins over a stored
  // one so a decoder never sees a stale copy.
  always_comb begin
    q_ready = FALSE;
    q_value = '0;
    if (q_tag != ZERO_ROB) begin
      if (cdb_valid && (cdb_tag == q_tag)) begin
        q_ready = TRUE;
        q_value = cdb_value;
      end else if (ent_valid[q_tag] && ent_ready[q_tag]) begin
        q_ready = TRUE;
        q_value = ent_value[q_tag];
      end
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ---------------------------------------------------------------------------
// rob_commit_ctrl
//   Circular reorder-buffer controller. Hands out ROB tags to the decoder,
//   captures results from the CDB, retires entries in order through the
//   register file's single writeback port and forwards captured results to
//   the decoder for busy operands.
//
//   clk           in   clock
//   rst           in   asynchronous active-high reset
//   flush         in   discard every entry (mispredict)
//   alloc_valid   in   decoder requests an entry
//   alloc_dest    in   destination register of the new entry
//   alloc_ready   out  a slot is free (from registered count)
//   alloc_tag     out  tag granted on alloc_valid && alloc_ready (= tail)
//   cdb_valid     in   result broadcast present
//   cdb_tag       in   tag of the broadcast result
//   cdb_value     in   broadcast result value
//   q1_tag/q2_tag in   operand tags read from the register file
//   q1_ready/..   out  forwarded value available
//   q1_value/..   out  forwarded value, 0 when not available
//   commit_valid  out  registered one-cycle retirement pulse
//   commit_reg    out  retired destination register, 0 when idle
//   commit_tag    out  retired tag (holds last value when idle)
//   commit_value  out  retired value (holds last value when idle)
//   count         out  number of occupied entries
//
//   Allocation handshake: a transfer happens on a rising clk edge where
//   alloc_valid and alloc_ready are both high; alloc_tag names the slot
//   granted by that transfer. alloc_ready depends only on registered state,
//   never on alloc_valid, and the decoder may raise or drop alloc_valid on
//   any cycle.
// ---------------------------------------------------------------------------
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [ROB_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic [ROB_W-1:0]  q1_tag,
  input  logic [ROB_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_value,
  output logic [DATA_W-1:0] q2_value,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_reg,
  output logic [ROB_W-1:0]  commit_tag,
  output logic [DATA_W-1:0] commit_value,
  output logic [ROB_W-1:0]  count
);

  // Pointers and occupancy
  logic [ROB_W-1:0] head;
  logic [ROB_W-1:0] tail;
  logic [ROB_W-1:0] count_q;

  // Entry storage, indexed directly by tag (slot 0 is never written valid)
  logic [ROB_SIZE-1:0]              ent_valid;
  logic [ROB_SIZE-1:0]              ent_ready;
  logic [ROB_SIZE-1:0][REG_W-1:0]   ent_dest;
  logic [ROB_SIZE-1:0][DATA_W-1:0]  ent_value;

  logic alloc_fire;
  logic commit_fire;
  logic cdb_hit;

  // Occupancy alone decides readiness; a retirement on the same edge does
  // not free a slot early, which keeps alloc_ready a short registered path.
  assign alloc_ready = (count_q < LAST_TAG);
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Head retires only from registered state, so a CDB capture into the
  // head slot becomes visible to retirement one edge later.
  assign commit_fire = ent_valid[head] && ent_ready[head];

  // Broadcasts to free slots or to tag 0 are dropped.
  assign cdb_hit = cdb_valid && (cdb_tag != ZERO_ROB) && ent_valid[cdb_tag];

  assign count = count_q;

  // -------------------------------------------------------------------------
  // Head / tail / count
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= FIRST_TAG;
      tail    <= FIRST_TAG;
      count_q <= ZERO_ROB;
    end else if (flush) begin
      head    <= FIRST_TAG;
      tail    <= FIRST_TAG;
      count_q <= ZERO_ROB;
    end else begin
      if (alloc_fire) begin
        tail <= next_tag(tail);
      end
      if (commit_fire) begin
        head <= next_tag(head);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + ONE_ROB;
        2'b01:   count_q <= count_q - ONE_ROB;
        default: count_q <= count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage
  //   The three updates cannot collide on one slot in a way that matters:
  //   alloc writes tail, which is free unless the buffer is full (and then
  //   alloc is blocked); commit clears head after any CDB write to it, and a
  //   CDB write to the free tail slot is dropped by cdb_hit.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_valid <= '0;
      ent_ready <= '0;
      ent_dest  <= '0;
      ent_value <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      ent_ready <= '0;
    end else begin
      if (cdb_hit) begin
        ent_ready[cdb_tag] <= TRUE;
        ent_value[cdb_tag] <= cdb_value;
      end
      if (commit_fire) begin
        ent_valid[head] <= FALSE;
        ent_ready[head] <= FALSE;
      end
      if (alloc_fire) begin
        ent_valid[tail] <= TRUE;
        ent_ready[tail] <= FALSE;
        ent_dest[tail]  <= alloc_dest;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register-file writeback port
  //   commit_reg returns to 0 when idle so the regfile sees no write even if
  //   it ignores commit_valid; tag/value keep their last retirement.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid <= FALSE;
      commit_reg   <= ZERO_REG;
      commit_tag   <= ZERO_ROB;
      commit_value <= '0;
    end else if (flush) begin
      commit_valid <= FALSE;
      commit_reg   <= ZERO_REG;
    end else if (commit_fire) begin
      commit_valid <= TRUE;
      commit_reg   <= ent_dest[head];
      commit_tag   <= head;
      commit_value <= ent_value[head];
    end else begin
      commit_valid <= FALSE;
      commit_reg   <= ZERO_REG;
    end
  end

  // -------------------------------------------------------------------------
  // Operand forwarding, one lookup per decoder query port
  // -------------------------------------------------------------------------
  rob_tag_forward u_fwd_q1 (
    .q_tag     (q1_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .ent_valid (ent_valid),
    .ent_ready (ent_ready),
    .ent_value (ent_value),
    .q_ready   (q1_ready),
    .q_value   (q1_value)
  );

  rob_tag_forward u_fwd_q2 (
    .q_tag     (q2_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .ent_valid (ent_valid),
    .ent_ready (ent_ready),
    .ent_value (ent_value),
    .q_ready   (q2_ready),
    .q_value   (q2_value)
  );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rob_commit_ctrl
//   Self-checking bench for rob_commit_ctrl. Every allocation pushes the
//   retirement it must eventually produce ({dest, tag, value}) to exp_q; a
//   negedge monitor pops and compares each commit. A vector table checks
//   operand forwarding; hand-written sequences cover latency, full/wrap,
//   flush and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_rob_commit_ctrl;
  import rob_commit_ctrl_pkg::*;

  localparam int REC_W = REG_W + ROB_W + DATA_W;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic [ROB_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic [ROB_W-1:0]  q1_tag;
  logic [ROB_W-1:0]  q2_tag;
  logic              q1_ready;
  logic              q2_ready;
  logic [DATA_W-1:0] q1_value;
  logic [DATA_W-1:0] q2_value;
  logic              commit_valid;
  logic [REG_W-1:0]  commit_reg;
  logic [ROB_W-1:0]  commit_tag;
  logic [DATA_W-1:0] commit_value;
  logic [ROB_W-1:0]  count;

  always #5 clk = ~clk;

  rob_commit_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .alloc_valid  (alloc_valid),
    .alloc_dest   (alloc_dest),
    .alloc_ready  (alloc_ready),
    .alloc_tag    (alloc_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .q1_tag       (q1_tag),
    .q2_tag       (q2_tag),
    .q1_ready     (q1_ready),
    .q2_ready     (q2_ready),
    .q1_value     (q1_value),
    .q2_value     (q2_value),
    .commit_valid (commit_valid),
    .commit_reg   (commit_reg),
    .commit_tag   (commit_tag),
    .commit_value (commit_value),
    .count        (count)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [REC_W-1:0]  exp_q[$];
  logic [ROB_W-1:0]  exp_tail;
  logic [DATA_W-1:0] plan_val [ROB_SIZE];

  function automatic logic [ROB_W-1:0] bump(input logic [ROB_W-1:0] t);
    if (t == 4'd15) return 4'd1;
    return t + 4'd1;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Commit monitor
  always @(negedge clk) begin
    logic [REC_W-1:0] rec;
    if (rst === 1'b0) begin
      if (commit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL commit_unexpected: got tag %0d reg %0d required no commit at %0t",
                   commit_tag, commit_reg, $time);
        end else begin
          rec = exp_q.pop_front();
          check("commit_reg",   DATA_W'(commit_reg), DATA_W'(rec[REC_W-1 -: REG_W]));
          check("commit_tag",   DATA_W'(commit_tag), DATA_W'(rec[DATA_W +: ROB_W]));
          check("commit_value", commit_value,        rec[DATA_W-1:0]);
        end
      end else begin
        check("idle_commit_reg", DATA_W'(commit_reg), '0);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks (inputs change 1ns after the rising edge)
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [REG_W-1:0] dest, input logic [DATA_W-1:0] val);
    alloc_valid = 1'b1;
    alloc_dest  = dest;
    #1;
    check("alloc_ready", DATA_W'(alloc_ready), 1);
    check("alloc_tag",   DATA_W'(alloc_tag),   DATA_W'(exp_tail));
    exp_q.push_back({dest, exp_tail, val});
    plan_val[exp_tail] = val;
    exp_tail = bump(exp_tail);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_cdb(input logic [ROB_W-1:0] tag);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_value = plan_val[tag];
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, exp_q.size(), 0);
  endtask

  // -------------------------------------------------------------------------
  // Forwarding vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic [ROB_W-1:0]  q1_tag;
    logic [ROB_W-1:0]  q2_tag;
    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              e1_ready;
    logic [DATA_W-1:0] e1_value;
    logic              e2_ready;
    logic [DATA_W-1:0] e2_value;
  } fwd_vec_t;

  fwd_vec_t vecs [8];

  // -------------------------------------------------------------------------
  // Test sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [ROB_W-1:0] t;

    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; q1_tag = '0; q2_tag = '0;
    exp_tail = 4'd1;
    for (int i = 0; i < ROB_SIZE; i++) plan_val[i] = '0;

    // State: entries 4..8 valid, 6 and 7 captured, head 4 not ready
    vecs[0] = '{4'd6,  4'd7, 1'b0, 4'd0,  32'h0,         1'b1, 32'h6666_0006, 1'b1, 32'h7777_0007};
    vecs[1] = '{4'd4,  4'd0, 1'b1, 4'd4,  32'h1234,      1'b1, 32'h1234,      1'b0, 32'h0};
    vecs[2] = '{4'd5,  4'd8, 1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    vecs[3] = '{4'd7,  4'd6, 1'b1, 4'd7,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h6666_0006};
    vecs[4] = '{4'd0,  4'd0, 1'b1, 4'd0,  32'h5555,      1'b0, 32'h0,         1'b0, 32'h0};
    vecs[5] = '{4'd10, 4'd3, 1'b0, 4'd0,  32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    vecs[6] = '{4'd12, 4'd12,1'b1, 4'd12, 32'hABCD,      1'b1, 32'hABCD,      1'b1, 32'hABCD};
    vecs[7] = '{4'd8,  4'd6, 1'b1, 4'd5,  32'h42,        1'b0, 32'h0,         1'b1, 32'h6666_0006};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_commit_valid", DATA_W'(commit_valid), 0);
    check("rst_commit_reg",   DATA_W'(commit_reg),   0);
    check("rst_commit_tag",   DATA_W'(commit_tag),   0);
    check("rst_commit_value", commit_value,          0);
    check("rst_count",        DATA_W'(count),        0);
    check("rst_alloc_ready",  DATA_W'(alloc_ready),  1);
    check("rst_alloc_tag",    DATA_W'(alloc_tag),    1);

    // Three allocations, no retirement yet
    do_alloc(5'd5, 32'h55);
    do_alloc(5'd6, 32'hAA);
    do_alloc(5'd7, 32'h77);
    check("alloc3_count",        DATA_W'(count),        3);
    check("alloc3_commit_valid", DATA_W'(commit_valid), 0);

    // Out-of-order results, in-order retirement
    do_cdb(4'd2);
    do_cdb(4'd1);
    check("cdb_head_no_same_edge_commit", DATA_W'(commit_valid), 0);
    tick();
    check("first_commit_valid", DATA_W'(commit_valid), 1);
    check("first_commit_tag",   DATA_W'(commit_tag),   1);
    tick();
    check("second_commit_tag", DATA_W'(commit_tag), 2);
    check("after_two_count",   DATA_W'(count),      1);
    do_cdb(4'd3);
    drain("drain_basic");
    check("drain_basic_count", DATA_W'(count), 0);

    // Forwarding table: tags 4..8, capture 6 and 7 only
    do_alloc(5'd1, 32'h4444_0004);
    do_alloc(5'd2, 32'h5555_0005);
    do_alloc(5'd3, 32'h6666_0006);
    do_alloc(5'd4, 32'h7777_0007);
    do_alloc(5'd5, 32'h8888_0008);
    do_cdb(4'd6);
    do_cdb(4'd7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      q1_tag = vecs[i].q1_tag;       q2_tag = vecs[i].q2_tag;
      cdb_valid = vecs[i].cdb_valid; cdb_tag = vecs[i].cdb_tag;
      cdb_value = vecs[i].cdb_value;
      #1;
      check($sformatf("fwd%0d_q1_ready", i), DATA_W'(q1_ready), DATA_W'(vecs[i].e1_ready));
      check($sformatf("fwd%0d_q1_value", i), q1_value,          vecs[i].e1_value);
      check($sformatf("fwd%0d_q2_ready", i), DATA_W'(q2_ready), DATA_W'(vecs[i].e2_ready));
      check($sformatf("fwd%0d_q2_value", i), q2_value,          vecs[i].e2_value);
      #1;
      cdb_valid = 1'b0; q1_tag = '0; q2_tag = '0;
    end
    tick();
    check("fwd_no_commit_count", DATA_W'(count), 5);
    do_cdb(4'd4);
    do_cdb(4'd5);
    do_cdb(4'd8);
    drain("drain_fwd");
    check("drain_fwd_count", DATA_W'(count), 0);

    // Simultaneous alloc and commit keeps count
    do_alloc(5'd9, 32'h0909_0909);
    do_cdb(4'd9);
    do_alloc(5'd10, 32'h0A0A_0A0A);
    check("alloc_commit_same_edge_count", DATA_W'(count), 1);
    do_cdb(4'd10);
    drain("drain_simul");

    // Fill to capacity starting at tag 11, wrapping through 15 -> 1
    for (int i = 0; i < 15; i++) begin
      do_alloc(REG_W'(i), (i == 0) ? 32'h99 : (32'hF000_0000 + 32'(i)));
    end
    check("full_count",       DATA_W'(count),       15);
    check("full_alloc_ready", DATA_W'(alloc_ready), 0);
    alloc_valid = 1'b1;
    alloc_dest  = 5'd3;
    tick();
    alloc_valid = 1'b0;
    check("full_ignored_count", DATA_W'(count),     15);
    check("full_ignored_tag",   DATA_W'(alloc_tag), DATA_W'(exp_tail));
    t = 4'd11;
    for (int i = 0; i < 15; i++) begin
      do_cdb(t);
      t = bump(t);
    end
    drain("drain_full");
    check("drain_full_count", DATA_W'(count), 0);

    // Flush beats a ready head, an alloc and a CDB on the same edge
    for (int i = 0; i < 5; i++) begin
      do_alloc(REG_W'(20 + i), 32'hC000_0000 + 32'(i));
    end
    do_cdb(4'd12);
    do_cdb(4'd11);
    flush = 1'b1; alloc_valid = 1'b1; alloc_dest = 5'd9;
    cdb_valid = 1'b1; cdb_tag = 4'd13; cdb_value = plan_val[13];
    exp_q.delete();
    tick();
    flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
    exp_tail = 4'd1;
    check("flush_count",        DATA_W'(count),        0);
    check("flush_alloc_tag",    DATA_W'(alloc_tag),    1);
    check("flush_alloc_ready",  DATA_W'(alloc_ready),  1);
    check("flush_commit_valid", DATA_W'(commit_valid), 0);
    q1_tag = 4'd12;
    #1;
    check("flush_entry_gone", DATA_W'(q1_ready), 0);
    q1_tag = '0;
    repeat (2) tick();
    check("flush_idle_commit", DATA_W'(commit_valid), 0);

    // Asynchronous reset in the middle of a retirement pulse
    do_alloc(5'd3, 32'h3333_0003);
    do_alloc(5'd4, 32'h4444_0004);
    do_alloc(5'd8, 32'h8888_0008);
    do_cdb(4'd1);
    tick();
    check("pre_rst_commit_tag", DATA_W'(commit_tag), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_tail = 4'd1;
    check("async_rst_commit_valid", DATA_W'(commit_valid), 0);
    check("async_rst_commit_reg",   DATA_W'(commit_reg),   0);
    check("async_rst_commit_tag",   DATA_W'(commit_tag),   0);
    check("async_rst_commit_value", commit_value,          0);
    check("async_rst_count",        DATA_W'(count),        0);
    check("async_rst_alloc_tag",    DATA_W'(alloc_tag),    1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Life after reset
    do_alloc(5'd17, 32'h1717_1717);
    do_cdb(4'd1);
    drain("drain_post_rst");
    check("post_rst_count", DATA_W'(count), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Circular reorder-buffer controller that owns ROB tag allocation and in-order retirement.
- Drives the register file's single writeback port: commit_reg, commit_tag, commit_value connect to the regfile's set_value, in_rob_entry_tag and in_new_value inputs.
- Sits between the decoder (allocation), the CDB (result capture) and the register file (commit).
- Also forwards captured-but-uncommitted results to the decoder for busy operands.

Parameters:
- ROB_SIZE, 16, number of tag slots; tag 0 is reserved as "no tag", so usable capacity is ROB_SIZE-1.
- ROB_W, 4, tag width, equal to log2(ROB_SIZE).
- DATA_W, 32, data width.
- REG_W, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  discard all entries (mispredict).
- alloc_valid  in  1  decoder requests an entry.
- alloc_dest  in  REG_W  destination register of the new entry.
- alloc_ready  out  1  an entry is free; combinational.
- alloc_tag  out  ROB_W  tag granted if alloc_valid && alloc_ready; combinational, equals tail.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  ROB_W  tag of the broadcast result.
- cdb_value  in  DATA_W  broadcast result value.
- q1_tag, q2_tag  in  ROB_W  operand tags read from the regfile.
- q1_ready, q2_ready  out  1  value for that tag is available; combinational.
- q1_value, q2_value  out  DATA_W  forwarded value; combinational.
- commit_valid  out  1  registered pulse, one retirement.
- commit_reg  out  REG_W  destination reg; 0 when no commit.
- commit_tag  out  ROB_W  tag being retired.
- commit_value  out  DATA_W  retired value.
- count  out  ROB_W  occupied entries.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset state:
  - head=tail=1, count=0, all entry valid/ready bits 0.
  - commit_valid=0, commit_reg=0, commit_tag=0, commit_value=0.
- Tag sequence: 1..ROB_SIZE-1; the successor of ROB_SIZE-1 is 1. Tag 0 is never allocated.
- Allocate:
  - alloc_ready = (count < ROB_SIZE-1), computed from registered count. A same-cycle commit does not free a slot early.
  - On an edge with alloc_valid && alloc_ready: entry[tail] gets valid=1, ready=0, dest=alloc_dest; tail advances.
- CDB capture:
  - On an edge with cdb_valid, if entry[cdb_tag] is valid: ready=1, value=cdb_value.
  - Broadcasts to invalid tags or tag 0 are ignored.
- Commit (at most one per cycle):
  - On an edge where entry[head] is valid && ready, evaluated from registered state: commit_valid=1, commit_reg=dest, commit_tag=head, commit_value=value.
  - In the same edge, entry[head] is invalidated and head advances.
  - Otherwise commit_valid=0 and commit_reg=0. commit_tag and commit_value hold their last values.
- Latency:
  - A CDB result captured at edge N commits at edge N+1 at the earliest. Commit outputs are visible during cycle N+1..N+2.
  - A CDB hit on head in the same cycle as head evaluation does not commit that cycle.
- dest=0 entries still retire: commit_valid=1, commit_reg=0, so the regfile ignores the write.
- Count update: count += alloc_fire − commit_fire. Simultaneous alloc and commit leaves count unchanged.
- Forwarding, per query port:
  - If cdb_valid && cdb_tag==qN_tag && qN_tag!=0: ready=1, value=cdb_value (bypass).
  - Else if entry[qN_tag] is valid && ready: ready=1, value=entry value.
  - Else ready=0, value=0.
  - Tag 0 always gives ready=0.
- Flush has priority over alloc, CDB and commit in the same edge:
  - head=tail=1, count=0, all valid=0.
  - commit_valid=0 on the next cycle.
  - A commit that was already registered before the flush edge is kept, not retracted.
- Full: count=ROB_SIZE-1 → alloc_ready=0; alloc_valid is ignored.
- Empty: no commit; outputs stay idle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Decomposition:
- Shared package/constant header holds: ROB_W, REG_W, DATA_W, ZERO_ROB, ZERO_REG, TRUE/FALSE, and the tag-increment-with-skip-zero helper (function/macro).
- One sub-module is natural: rob_tag_forward. It is the combinational lookup plus CDB bypass, instantiated twice (q1, q2).
- Entry storage and head/tail/count logic remain in rob_commit_ctrl.

Test Plan:
- Reset, then 3 allocs with dest 5,6,7 → alloc_tag 1,2,3; count=3; no commit_valid.
- CDB tag 2 value 0xAA, then tag 1 value 0x55 → commits in order: (reg5, tag1, 0x55), then next cycle (reg6, tag2, 0xAA); count=1.
- Allocate 15 entries → alloc_ready=0 at count=15; 16th alloc_valid ignored. After commits, tags wrap from 15 to 1, never 0.
- cdb_valid tag 4 value 0x1234 with q1_tag=4 in the same cycle → q1_ready=1, q1_value=0x1234 combinationally. q2_tag=0 → q2_ready=0.
- Entry dest=0, CDB value 0x99 → commit_valid=1, commit_reg=0, commit_value=0x99.
- 5 entries, 2 ready at head; flush with simultaneous alloc_valid and CDB → next cycle count=0, alloc_tag=1, commit_valid=0. Assert rst mid-stream → all outputs 0 immediately, before the next clk edge.
